core_dispatch_ctrl: RTL and testbench

Backend-side receiver of the frontend's decoded instruction stream and originator of the frontend control response. Accepts up to two decoded instructions per cycle into a small in-order queue and reports the accepted count back as the frontend FIFO read count. Presents the queue head to issue and turns backend events into frontend control: redirect, idle/interrupt wake, and icache maintenance ops.

---
 rtl/core_dispatch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_core_dispatch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch_ctrl.sv
// Backend dispatch front: a two-wide in-order instruction queue plus the
// redirect, idle/wake and icache maintenance controls sent back to the frontend.
module core_dispatch_ctrl #(
    parameter int PAYLOAD_W = 128,
    parameter int QDEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             inst_valid_i,
    input  logic [2*PAYLOAD_W-1:0] inst_i,
    output logic [1:0]             take_num_o,
    output logic [1:0]             issue_valid_o,
    output logic [2*PAYLOAD_W-1:0] issue_o,
    input  logic [1:0]             issue_num_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_target_i,
    input  logic                   wait_inst_i,
    input  logic                   int_detect_i,
    input  logic                   cacop_valid_i,
    input  logic [1:0]             cacop_i,
    input  logic [31:0]            cacop_addr_i,
    output logic                   cacop_done_o,
    output logic                   rst_jmp_o,
    output logic [31:0]            rst_jmp_target_o,
    output logic                   wait_inst_o,
    output logic                   int_detect_o,
    output logic                   icache_op_valid_o,
    output logic [1:0]             icache_op_o,
    output logic [31:0]            icacheop_addr_o,
    input  logic                   icache_ready_i
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic {RUN, IDLE} run_state_e;
    typedef enum logic [1:0] {C_IDLE, C_SEND, C_GAP, C_WAIT} cac_state_e;

    logic [PAYLOAD_W-1:0] mem_q [QDEPTH];
    logic [PAYLOAD_W-1:0] mem_d [QDEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     pop_cnt, free_cnt;
    logic [1:0]           pop2, take_num;
    logic                 issue_block;

    run_state_e           run_q, run_d;
    cac_state_e           cac_q, cac_d;
    logic [1:0]           cac_op_q, cac_op_d;
    logic [31:0]          cac_addr_q, cac_addr_d;
    logic                 done_q, done_d;
    logic                 rst_jmp_q, rst_jmp_d;
    logic [31:0]          rst_jmp_target_q, rst_jmp_target_d;
    logic                 wait_q, wait_d, int_q, int_d;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Acceptance depends only on registered occupancy, never on issue_num_i.
    always_comb begin
        pop2     = {1'b0, inst_valid_i[0]} + {1'b0, inst_valid_i[1]};
        pop_cnt  = CNT_W'(pop2);
        free_cnt = DEPTH_C - count_q;
        take_num = 2'd0;
        if (!rst && !redirect_i && !rst_jmp_q) begin
            take_num = (pop_cnt < free_cnt) ? pop2 : free_cnt[1:0];
        end
    end

    assign take_num_o    = take_num;
    assign issue_block   = rst || redirect_i || rst_jmp_q || (run_q == IDLE);
    assign issue_valid_o = issue_block ? 2'b00 : {count_q >= CNT_W'(2), count_q != '0};
    assign issue_o       = {mem_q[head_p1], mem_q[head_q]};

    always_comb begin
        count_d = count_q + CNT_W'(take_num) - CNT_W'(issue_num_i);
        head_d  = head_q + PTR_W'(issue_num_i);
        tail_d  = tail_q + PTR_W'(take_num);
        if (redirect_i) begin
            count_d = '0;
            head_d  = tail_q;
        end
    end

    // Slot 0 lands at tail, slot 1 at tail+1.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
        assign mem_d[gi] = (take_num != 2'd0 && tail_q == PTR_W'(gi)) ? inst_i[PAYLOAD_W-1:0] :
                           (take_num == 2'd2 && tail_p1 == PTR_W'(gi)) ? inst_i[2*PAYLOAD_W-1:PAYLOAD_W] :
                           mem_q[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        run_d = run_q;
        case (run_q)
            RUN:     if (wait_inst_i && !int_detect_i) run_d = IDLE;
            IDLE:    if (int_detect_i) run_d = RUN;
            default: run_d = RUN;
        endcase
    end

    // done_q guards C_IDLE so the still-held request is not re-accepted on the done cycle.
    always_comb begin
        cac_d             = cac_q;
        cac_op_d          = cac_op_q;
        cac_addr_d        = cac_addr_q;
        done_d            = 1'b0;
        icache_op_valid_o = 1'b0;
        case (cac_q)
            C_IDLE: begin
                if (cacop_valid_i && !done_q) begin
                    cac_d      = C_SEND;
                    cac_op_d   = cacop_i;
                    cac_addr_d = cacop_addr_i;
                end
            end
            C_SEND: begin
                icache_op_valid_o = 1'b1;
                cac_d             = C_GAP;
            end
            C_GAP:  cac_d = C_WAIT;
            C_WAIT: begin
                if (icache_ready_i) begin
                    done_d = 1'b1;
                    cac_d  = C_IDLE;
                end
            end
            default: cac_d = C_IDLE;
        endcase
    end

    assign rst_jmp_d        = redirect_i;
    assign rst_jmp_target_d = redirect_i ? redirect_target_i : rst_jmp_target_q;
    assign wait_d           = wait_inst_i;
    assign int_d            = int_detect_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            run_q            <= RUN;
            cac_q            <= C_IDLE;
            cac_op_q         <= 2'd0;
            cac_addr_q       <= 32'd0;
            done_q           <= 1'b0;
            rst_jmp_q        <= 1'b0;
            rst_jmp_target_q <= 32'd0;
            wait_q           <= 1'b0;
            int_q            <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            run_q            <= run_d;
            cac_q            <= cac_d;
            cac_op_q         <= cac_op_d;
            cac_addr_q       <= cac_addr_d;
            done_q           <= done_d;
            rst_jmp_q        <= rst_jmp_d;
            rst_jmp_target_q <= rst_jmp_target_d;
            wait_q           <= wait_d;
            int_q            <= int_d;
        end
    end

    assign rst_jmp_o        = rst_jmp_q;
    assign rst_jmp_target_o = rst_jmp_target_q;
    assign wait_inst_o      = wait_q;
    assign int_detect_o     = int_q;
    assign icache_op_o      = cac_op_q;
    assign icacheop_addr_o  = cac_addr_q;
    assign cacop_done_o     = done_q;

    assert property (@(posedge clk) disable iff (rst) inst_valid_i != 2'b10);
    assert property (@(posedge clk) disable iff (rst)
        issue_num_i <= ({1'b0, issue_valid_o[0]} + {1'b0, issue_valid_o[1]}));
endmodule

// File: tb/tb_core_dispatch_ctrl.sv
// Scoreboard bench for core_dispatch_ctrl: a queue-based reference model predicts
// every cycle's outputs; a separate monitor pops and compares them.
module tb_core_dispatch_ctrl;
    localparam int PW    = 128;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      inst_valid_i, take_num_o, issue_valid_o, issue_num_i;
    logic [2*PW-1:0] inst_i, issue_o;
    logic            redirect_i, wait_inst_i, int_detect_i, cacop_valid_i, icache_ready_i;
    logic [31:0]     redirect_target_i, cacop_addr_i, rst_jmp_target_o, icacheop_addr_o;
    logic [1:0]      cacop_i, icache_op_o;
    logic            cacop_done_o, rst_jmp_o, wait_inst_o, int_detect_o, icache_op_valid_o;

    always #5 clk = ~clk;

    core_dispatch_ctrl #(.PAYLOAD_W(PW), .QDEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_i(inst_i), .take_num_o(take_num_o),
        .issue_valid_o(issue_valid_o), .issue_o(issue_o), .issue_num_i(issue_num_i),
        .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
        .wait_inst_i(wait_inst_i), .int_detect_i(int_detect_i),
        .cacop_valid_i(cacop_valid_i), .cacop_i(cacop_i), .cacop_addr_i(cacop_addr_i),
        .cacop_done_o(cacop_done_o), .rst_jmp_o(rst_jmp_o), .rst_jmp_target_o(rst_jmp_target_o),
        .wait_inst_o(wait_inst_o), .int_detect_o(int_detect_o),
        .icache_op_valid_o(icache_op_valid_o), .icache_op_o(icache_op_o),
        .icacheop_addr_o(icacheop_addr_o), .icache_ready_i(icache_ready_i)
    );

    typedef struct {
        bit          chk_all;
        bit          chk_tgt;
        bit          chk_op;
        bit [1:0]    take;
        bit [1:0]    iv;
        bit [PW-1:0] p0;
        bit [PW-1:0] p1;
        bit          rj;
        bit [31:0]   tgt;
        bit          wo;
        bit          io;
        bit          opv;
        bit [1:0]    op;
        bit [31:0]   addr;
        bit          done;
    } exp_t;

    exp_t        expq[$];
    logic [PW-1:0] m_q[$];
    bit          m_idle, m_rj, m_wo, m_io, m_busy, m_done, m_any_redir, m_any_cac;
    logic [31:0] m_tgt, m_caddr;
    logic [1:0]  m_cop;
    int          m_age;
    int          checks = 0;
    int          errors = 0;

    bit          s_rst, s_redir, s_wait, s_int, s_cv, s_rdy;
    logic [1:0]  s_iv, s_inum, s_cop;
    logic [31:0] s_tgt, s_caddr;
    bit          last_done;

    function automatic void chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [PW-1:0] rand_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idle = 0; m_rj = 0; m_wo = 0; m_io = 0;
        m_busy = 0; m_done = 0; m_any_redir = 0; m_any_cac = 0;
        m_tgt = 0; m_caddr = 0; m_cop = 0; m_age = 0;
    endtask

    task automatic clear_stim();
        s_rst = 0; s_redir = 0; s_wait = 0; s_int = 0; s_cv = 0; s_rdy = 0;
        s_iv = 2'b00; s_inum = 2'd0; s_cop = 2'd0; s_tgt = 32'd0; s_caddr = 32'd0;
    endtask

    // One cycle: drive stimulus, push the predicted outputs, advance the model.
    task automatic step();
        exp_t          e;
        int            sz, pop, free, take, ivc, n;
        bit            done_next;
        logic [PW-1:0] pl0, pl1;
        @(negedge clk);
        pl0  = rand_payload();
        pl1  = rand_payload();
        sz   = m_q.size();
        pop  = int'(s_iv[0]) + int'(s_iv[1]);
        free = DEPTH - sz;
        take = (s_rst || s_redir || m_rj) ? 0 : ((pop < free) ? pop : free);
        ivc  = (s_redir || m_rj || m_idle) ? 0 : ((sz < 2) ? sz : 2);
        n    = s_rst ? 0 : ((int'(s_inum) < ivc) ? int'(s_inum) : ivc);

        e.chk_all = !s_rst;
        e.chk_tgt = m_rj || !m_any_redir;
        e.chk_op  = (m_busy && m_age == 1) || !m_any_cac;
        e.take    = 2'(take);
        e.iv      = (ivc == 2) ? 2'b11 : ((ivc == 1) ? 2'b01 : 2'b00);
        e.p0      = (sz > 0) ? m_q[0] : '0;
        e.p1      = (sz > 1) ? m_q[1] : '0;
        e.rj      = m_rj;
        e.tgt     = m_tgt;
        e.wo      = m_wo;
        e.io      = m_io;
        e.opv     = m_busy && (m_age == 1);
        e.op      = m_cop;
        e.addr    = m_caddr;
        e.done    = m_done;
        last_done = m_done;

        rst = s_rst; inst_valid_i = s_iv; inst_i = {pl1, pl0}; issue_num_i = 2'(n);
        redirect_i = s_redir; redirect_target_i = s_tgt;
        wait_inst_i = s_wait; int_detect_i = s_int;
        cacop_valid_i = s_cv; cacop_i = s_cop; cacop_addr_i = s_caddr; icache_ready_i = s_rdy;
        expq.push_back(e);

        if (s_rst) begin
            model_reset();
        end else begin
            if (s_redir) begin
                m_q.delete();
            end else begin
                repeat (n) m_q.delete(0);
                if (take >= 1) m_q.push_back(pl0);
                if (take == 2) m_q.push_back(pl1);
            end
            m_rj = s_redir;
            if (s_redir) begin
                m_tgt = s_tgt;
                m_any_redir = 1;
            end
            m_wo = s_wait;
            m_io = s_int;
            if (!m_idle && s_wait && !s_int) m_idle = 1;
            else if (m_idle && s_int) m_idle = 0;
            done_next = m_busy && (m_age >= 3) && s_rdy;
            if (m_busy) begin
                if (done_next) m_busy = 0;
                else m_age++;
            end else if (s_cv && !m_done) begin
                m_busy = 1; m_age = 1; m_cop = s_cop; m_caddr = s_caddr; m_any_cac = 1;
            end
            m_done = done_next;
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                cyc++;
                $display("cyc=%0d rst=%0b take=%0d iv=%b inum=%0d rj=%0b opv=%0b done=%0b",
                         cyc, rst, take_num_o, issue_valid_o, issue_num_i, rst_jmp_o,
                         icache_op_valid_o, cacop_done_o);
                chk("take_num", PW'(take_num_o), PW'(e.take));
                if (e.chk_all) begin
                    chk("issue_valid", PW'(issue_valid_o), PW'(e.iv));
                    if (e.iv[0]) chk("issue_head", issue_o[PW-1:0], e.p0);
                    if (e.iv[1]) chk("issue_head1", issue_o[2*PW-1:PW], e.p1);
                    chk("rst_jmp", PW'(rst_jmp_o), PW'(e.rj));
                    if (e.chk_tgt) chk("rst_jmp_target", PW'(rst_jmp_target_o), PW'(e.tgt));
                    chk("wait_inst_o", PW'(wait_inst_o), PW'(e.wo));
                    chk("int_detect_o", PW'(int_detect_o), PW'(e.io));
                    chk("icache_op_valid", PW'(icache_op_valid_o), PW'(e.opv));
                    if (e.chk_op) begin
                        chk("icache_op", PW'(icache_op_o), PW'(e.op));
                        chk("icacheop_addr", PW'(icacheop_addr_o), PW'(e.addr));
                    end
                    chk("cacop_done", PW'(cacop_done_o), PW'(e.done));
                end
            end
        end
    end

    initial begin
        bit hold = 0;
        rst = 1; inst_valid_i = 0; inst_i = '0; issue_num_i = 0; redirect_i = 0;
        redirect_target_i = 0; wait_inst_i = 0; int_detect_i = 0; cacop_valid_i = 0;
        cacop_i = 0; cacop_addr_i = 0; icache_ready_i = 0;
        model_reset();
        clear_stim();
        s_rst = 1; repeat (2) step(); s_rst = 0;

        // fill/drain, first offset by one entry so the drain crosses the wrap
        s_iv = 2'b01; step();
        s_iv = 2'b00; s_inum = 2'd1; step(); s_inum = 2'd0;
        s_iv = 2'b11; repeat (4) step();
        s_iv = 2'b00; s_inum = 2'd2; repeat (2) step(); s_inum = 2'd0; step();

        // partial accept at count 3
        s_iv = 2'b11; step();
        s_iv = 2'b01; step();
        s_iv = 2'b11; s_inum = 2'd2; step();
        s_iv = 2'b01; s_inum = 2'd0; step();

        // redirect at count 3, then back-to-back redirects
        s_iv = 2'b11; s_redir = 1; s_tgt = 32'h1c00_0100; step();
        s_redir = 0; step(); step();
        s_redir = 1; s_tgt = 32'h1c00_0200; step();
        s_tgt = 32'h1c00_0300; step();
        s_redir = 0; s_iv = 2'b00; repeat (2) step();

        // idle with a non-empty queue, wake, then simultaneous wait+int
        s_iv = 2'b11; step(); s_iv = 2'b00;
        s_wait = 1; step(); s_wait = 0;
        repeat (3) step();
        s_int = 1; step(); s_int = 0;
        s_inum = 2'd2; step(); s_inum = 2'd0;
        s_wait = 1; s_int = 1; step(); s_wait = 0; s_int = 0;
        s_iv = 2'b01; s_inum = 2'd1; repeat (2) step(); s_iv = 2'b00; s_inum = 2'd0;

        // cacop with ready low for five cycles and a changed op held during C_WAIT
        s_cv = 1; s_cop = 2'd2; s_caddr = 32'h8000_1000; step();
        repeat (2) step();
        s_cop = 2'd1; s_caddr = 32'h0000_4444;
        repeat (3) step();
        s_rdy = 1; step(); s_rdy = 0;
        step();
        s_cv = 0; repeat (2) step();

        // reset with the queue full and a cacop in C_WAIT
        s_iv = 2'b11; repeat (3) step();
        s_cv = 1; s_cop = 2'd3; s_caddr = 32'h0000_0040; repeat (4) step();
        s_rst = 1; step();
        clear_stim(); repeat (2) step();

        for (int c = 0; c < 1500; c++) begin
            s_rst = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 2))
                0:       s_iv = 2'b00;
                1:       s_iv = 2'b01;
                default: s_iv = 2'b11;
            endcase
            s_inum  = (((c / 150) % 2) == 1) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 2));
            s_redir = ($urandom_range(0, 19) == 0);
            s_tgt   = $urandom;
            s_wait  = ($urandom_range(0, 24) == 0);
            s_int   = ($urandom_range(0, 9) == 0);
            if (!hold && $urandom_range(0, 9) == 0) begin
                hold = 1; s_cop = 2'($urandom_range(0, 3)); s_caddr = $urandom;
            end
            s_cv  = hold;
            s_rdy = ($urandom_range(0, 3) == 0);
            step();
            if (last_done) hold = 0;
        end

        clear_stim();
        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", PW'(expq.size()), PW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
